// File: rtl/stop_watch_ctrl_mlap_if.sv
// Lap FIFO read port of the stopwatch controller.
// The controller takes the slave side; whoever pops laps takes the master side.
interface stop_watch_ctrl_mlap_if #(
   parameter int unsigned TIME_W    = 24,
   parameter int unsigned LAP_DEPTH = 4
);
   logic                         lap_rd;
   logic                         lap_valid;
   logic [TIME_W-1:0]            lap_data;
   logic [$clog2(LAP_DEPTH):0]   lap_cnt;
   logic                         lap_ovf;

   modport master (
      output lap_rd,
      input  lap_valid,
      input  lap_data,
      input  lap_cnt,
      input  lap_ovf
   );

   modport slave (
      input  lap_rd,
      output lap_valid,
      output lap_data,
      output lap_cnt,
      output lap_ovf
   );
endinterface

// File: rtl/stop_watch_ctrl_mlap.sv
// Stopwatch control FSM (IDLE/RUN/PAUSE) with long-press clear, N display modes
// and a lap-capture FIFO. Button decisions happen only on slow-tick rising edges;
// counter/LED outputs are re-registered on the tick falling edge.
module stop_watch_ctrl_mlap #(
   parameter int unsigned TIME_W     = 24,
   parameter int unsigned LAP_DEPTH  = 4,
   parameter int unsigned DISP_MODES = 2,
   parameter int unsigned LONG_TICKS = 100
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pls_tick,
   input  logic                  start_stop_btn,
   input  logic                  clr_btn,
   input  logic                  lap_btn,
   input  logic [TIME_W-1:0]     time_in,
   output logic                  cnt_en,
   output logic                  clr_plso,
   output logic [1:0]            disp_mode,
   output logic [1:0]            stm,
   output logic [2:0]            ld0_rgb,
   output logic [2:0]            ld1_rgb,
   stop_watch_ctrl_mlap_if.slave lap_if
);

   localparam int unsigned PtrW  = $clog2(LAP_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);

   localparam int unsigned BtnStart = 0;
   localparam int unsigned BtnClr   = 1;
   localparam int unsigned BtnLap   = 2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StHalt  = 2'd3
   } state_e;

   logic              p0_q, p0_d, p1_q, p1_d;
   logic              tick_r, tick_f;
   logic [2:0]        btn_s0_q, btn_s0_d, btn_s1_q, btn_s1_d;
   logic [2:0]        btn_rise, btn_fall;
   logic [HoldW-1:0]  hold_q, hold_d;
   state_e            stm_q, stm_d;
   logic [1:0]        disp_mode_q, disp_mode_d;
   logic              clr_pls_q, clr_pls_d;
   logic              cnt_en_q, cnt_en_d;
   logic              clr_plso_q, clr_plso_d;
   logic [2:0]        ld0_q, ld0_d, ld1_q, ld1_d;
   logic [TIME_W-1:0] mem_q [LAP_DEPTH];
   logic [TIME_W-1:0] mem_d [LAP_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              long_press, short_press, lap_push, lap_pop, fifo_full, push_ok;

   // Tick edge detection and event qualification from the sampled buttons.
   always_comb begin
      p0_d     = pls_tick;
      p1_d     = p0_q;
      tick_r   = p0_q & ~p1_q;
      tick_f   = ~p0_q & p1_q;
      btn_rise = btn_s0_q & ~btn_s1_q;
      btn_fall = ~btn_s0_q & btn_s1_q;
      // A fresh clr press or a start press in the same tick must not trigger the clear.
      long_press  = tick_r & btn_s0_q[BtnClr] & ~btn_rise[BtnClr] & ~btn_rise[BtnStart]
                    & (stm_q == StPause) & (hold_q == HoldW'(LONG_TICKS - 1));
      short_press = tick_r & btn_fall[BtnClr] & (hold_q < HoldW'(LONG_TICKS - 1))
                    & (stm_q != StIdle);
      lap_push    = tick_r & btn_rise[BtnLap] & (stm_q == StRun);
   end

   // Button sampling, hold counter, state machine and display mode.
   always_comb begin
      btn_s0_d    = btn_s0_q;
      btn_s1_d    = btn_s1_q;
      hold_d      = hold_q;
      stm_d       = stm_q;
      disp_mode_d = disp_mode_q;
      clr_pls_d   = clr_pls_q;
      if (tick_r) begin
         btn_s1_d  = btn_s0_q;
         btn_s0_d  = {lap_btn, clr_btn, start_stop_btn};
         clr_pls_d = long_press;
         if (btn_rise[BtnClr]) begin
            hold_d = '0;
         end else if (btn_s0_q[BtnClr] && (hold_q < HoldW'(LONG_TICKS))) begin
            hold_d = hold_q + HoldW'(1);
         end
         unique case (stm_q)
            StIdle:  if (btn_rise[BtnStart]) stm_d = StRun;
            StRun:   if (btn_rise[BtnStart]) stm_d = StPause;
            StPause: begin
               if (btn_rise[BtnStart]) begin
                  stm_d = StRun;
               end else if (long_press) begin
                  stm_d = StIdle;
               end
            end
            default: stm_d = stm_q;
         endcase
         if (short_press) begin
            disp_mode_d = (disp_mode_q == 2'(DISP_MODES - 1)) ? 2'd0 : disp_mode_q + 2'd1;
         end
      end
      if (stm_d == StIdle) begin
         disp_mode_d = 2'd0;
      end
   end

   // Lap FIFO: flush beats push; pop frees a slot for a push in the same clock.
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      lap_pop   = lap_if.lap_rd & (cnt_q != '0);
      fifo_full = (cnt_q == CntW'(LAP_DEPTH));
      push_ok   = lap_push & (~fifo_full | lap_pop);
      if (long_press) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end else begin
         if (lap_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         if (push_ok) begin
            mem_d[wr_ptr_q] = time_in;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
         end
         if (lap_push && !push_ok) begin
            ovf_d = 1'b1;
         end
         cnt_d = cnt_q + CntW'(push_ok) - CntW'(lap_pop);
      end
   end

   // Outputs refreshed half a tick after the state change.
   always_comb begin
      cnt_en_d   = cnt_en_q;
      clr_plso_d = clr_plso_q;
      ld0_d      = ld0_q;
      ld1_d      = ld1_q;
      if (tick_f) begin
         cnt_en_d   = (stm_q == StRun);
         clr_plso_d = clr_pls_q;
         unique case (stm_q)
            StIdle:  ld0_d = 3'b010;
            StRun:   ld0_d = 3'b001;
            StPause: ld0_d = 3'b111;
            default: ld0_d = 3'b000;
         endcase
         unique case (disp_mode_q)
            2'd0:    ld1_d = 3'b010;
            2'd1:    ld1_d = 3'b001;
            2'd2:    ld1_d = 3'b100;
            default: ld1_d = 3'b110;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0_q        <= 1'b0;
         p1_q        <= 1'b0;
         btn_s0_q    <= '0;
         btn_s1_q    <= '0;
         hold_q      <= '0;
         stm_q       <= StIdle;
         disp_mode_q <= 2'd0;
         clr_pls_q   <= 1'b0;
         cnt_en_q    <= 1'b0;
         clr_plso_q  <= 1'b0;
         ld0_q       <= 3'b010;
         ld1_q       <= 3'b010;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
      end else begin
         p0_q        <= p0_d;
         p1_q        <= p1_d;
         btn_s0_q    <= btn_s0_d;
         btn_s1_q    <= btn_s1_d;
         hold_q      <= hold_d;
         stm_q       <= stm_d;
         disp_mode_q <= disp_mode_d;
         clr_pls_q   <= clr_pls_d;
         cnt_en_q    <= cnt_en_d;
         clr_plso_q  <= clr_plso_d;
         ld0_q       <= ld0_d;
         ld1_q       <= ld1_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
      end
   end

   assign cnt_en           = cnt_en_q;
   assign clr_plso         = clr_plso_q;
   assign disp_mode        = disp_mode_q;
   assign stm              = stm_q;
   assign ld0_rgb          = ld0_q;
   assign ld1_rgb          = ld1_q;
   assign lap_if.lap_valid = (cnt_q != '0);
   assign lap_if.lap_data  = mem_q[rd_ptr_q];
   assign lap_if.lap_cnt   = cnt_q;
   assign lap_if.lap_ovf   = ovf_q;

endmodule

// File: tb/tb_stop_watch_ctrl_mlap.sv
// Bench for stop_watch_ctrl_mlap: directed scenarios plus random button traffic,
// checked after every tick against a tick-level behavioural model.
module tb_stop_watch_ctrl_mlap;

   localparam int unsigned TW    = 16;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DM    = 3;
   localparam int unsigned LT    = 100;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pls_tick = 1'b0;
   logic          start_stop_btn = 1'b0;
   logic          clr_btn = 1'b0;
   logic          lap_btn = 1'b0;
   logic [TW-1:0] time_in = '0;
   logic          cnt_en, clr_plso;
   logic [1:0]    disp_mode, stm;
   logic [2:0]    ld0_rgb, ld1_rgb;

   stop_watch_ctrl_mlap_if #(.TIME_W(TW), .LAP_DEPTH(DEPTH)) lap_if ();

   stop_watch_ctrl_mlap #(
      .TIME_W(TW), .LAP_DEPTH(DEPTH), .DISP_MODES(DM), .LONG_TICKS(LT)
   ) dut (
      .clk(clk), .rst(rst), .pls_tick(pls_tick), .start_stop_btn(start_stop_btn),
      .clr_btn(clr_btn), .lap_btn(lap_btn), .time_in(time_in), .cnt_en(cnt_en),
      .clr_plso(clr_plso), .disp_mode(disp_mode), .stm(stm), .ld0_rgb(ld0_rgb),
      .ld1_rgb(ld1_rgb), .lap_if(lap_if)
   );

   always #4 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: per-tick samples of {lap,clr,start}, clr run lengths, state, mode, laps.
   logic [2:0] m_cur, m_prev;
   int         m_run, m_prev_run;
   int         m_stm, m_mode;
   int         m_q[$];
   bit         m_ovf, m_cnt_en, m_clr_o;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] led0(input int s);
      logic [2:0] tbl [4] = '{3'b010, 3'b001, 3'b111, 3'b000};
      return tbl[s];
   endfunction

   function automatic logic [2:0] led1(input int m);
      logic [2:0] tbl [4] = '{3'b010, 3'b001, 3'b100, 3'b110};
      return tbl[m];
   endfunction

   task automatic model_reset();
      m_cur = '0; m_prev = '0; m_run = 0; m_prev_run = 0;
      m_stm = 0; m_mode = 0; m_q.delete();
      m_ovf = 0; m_cnt_en = 0; m_clr_o = 0;
   endtask

   // Decisions use the samples taken on earlier ticks; new samples land afterwards.
   task automatic model_step(input logic [2:0] btn, input int t, input bit pop_mid);
      bit sr, cf, lr, lng, sht, push;
      sr   = m_cur[0] && !m_prev[0];
      cf   = !m_cur[1] && m_prev[1];
      lr   = m_cur[2] && !m_prev[2];
      lng  = (m_stm == 2) && !sr && m_cur[1] && (m_run == LT + 1);
      sht  = cf && (m_prev_run < LT) && (m_stm != 0);
      push = lr && (m_stm == 1);
      if (pop_mid && m_q.size() > 0) void'(m_q.pop_front());
      if (lng) begin
         m_q.delete();
         m_ovf = 0;
      end else if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(t);
         else m_ovf = 1;
      end
      case (m_stm)
         0: if (sr) m_stm = 1;
         1: if (sr) m_stm = 2;
         2: if (sr) m_stm = 1; else if (lng) m_stm = 0;
         default: ;
      endcase
      if (sht) m_mode = (m_mode + 1) % DM;
      if (m_stm == 0) m_mode = 0;
      m_clr_o    = lng;
      m_cnt_en   = (m_stm == 1);
      m_prev     = m_cur;
      m_cur      = btn;
      m_prev_run = m_run;
      m_run      = btn[1] ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
   endtask

   task automatic check_all(input string w);
      check_val({w, ".stm"}, 32'(stm), 32'(m_stm));
      check_val({w, ".mode"}, 32'(disp_mode), 32'(m_mode));
      check_val({w, ".cnt_en"}, 32'(cnt_en), 32'(m_cnt_en));
      check_val({w, ".clr_plso"}, 32'(clr_plso), 32'(m_clr_o));
      check_val({w, ".ld0"}, 32'(ld0_rgb), 32'(led0(m_stm)));
      check_val({w, ".ld1"}, 32'(ld1_rgb), 32'(led1(m_mode)));
      check_val({w, ".lap_cnt"}, 32'(lap_if.lap_cnt), 32'(m_q.size()));
      check_val({w, ".lap_valid"}, 32'(lap_if.lap_valid), 32'(m_q.size() > 0));
      check_val({w, ".lap_ovf"}, 32'(lap_if.lap_ovf), 32'(m_ovf));
      if (m_q.size() > 0) check_val({w, ".lap_data"}, 32'(lap_if.lap_data), 32'(m_q[0]));
   endtask

   // One full tick period; pop_mid pulses lap_rd on the tick_r clock.
   task automatic tick(input bit st, input bit cl, input bit lp, input int t, input bit pop_mid,
                       input string w);
      @(negedge clk);
      start_stop_btn = st; clr_btn = cl; lap_btn = lp; time_in = TW'(t); pls_tick = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (pop_mid) lap_if.lap_rd = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lap_if.lap_rd = 1'b0;
      model_step({lp, cl, st}, int'(time_in), pop_mid);
      repeat (2) @(negedge clk);
      pls_tick = 1'b0;
      repeat (4) @(negedge clk);
      check_all(w);
   endtask

   task automatic pop_between(input string w);
      @(negedge clk);
      if (m_q.size() > 0) check_val({w, ".pop_data"}, 32'(lap_if.lap_data), 32'(m_q[0]));
      lap_if.lap_rd = 1'b1;
      @(negedge clk);
      lap_if.lap_rd = 1'b0;
      if (m_q.size() > 0) void'(m_q.pop_front());
   endtask

   task automatic do_reset();
      @(negedge clk);
      start_stop_btn = 0; clr_btn = 0; lap_btn = 0; pls_tick = 0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      bit st, cl, lp;
      int pulses;
      lap_if.lap_rd = 1'b0;
      model_reset();
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst.stm", 32'(stm), 0);
      check_val("rst.mode", 32'(disp_mode), 0);
      check_val("rst.cnt_en", 32'(cnt_en), 0);
      check_val("rst.clr_plso", 32'(clr_plso), 0);
      check_val("rst.ld0", 32'(ld0_rgb), 32'h2);
      check_val("rst.ld1", 32'(ld1_rgb), 32'h2);
      check_val("rst.lap_cnt", 32'(lap_if.lap_cnt), 0);
      check_val("rst.lap_valid", 32'(lap_if.lap_valid), 0);
      check_val("rst.lap_ovf", 32'(lap_if.lap_ovf), 0);
      check_val("rst.lap_data", 32'(lap_if.lap_data), 0);
      rst = 1'b1;

      // Start press held 3 ticks -> RUN; second press -> PAUSE.
      repeat (3) tick(1, 0, 0, 0, 0, "start1");
      repeat (2) tick(0, 0, 0, 0, 0, "start1r");
      check_val("run.stm", 32'(stm), 1);
      check_val("run.ld0", 32'(ld0_rgb), 32'h1);
      tick(1, 0, 0, 0, 0, "start2");
      repeat (2) tick(0, 0, 0, 0, 0, "start2r");
      check_val("pause.cnt_en", 32'(cnt_en), 0);
      check_val("pause.ld0", 32'(ld0_rgb), 32'h7);

      // Long clr hold in PAUSE -> single clear pulse, back to IDLE.
      pulses = 0;
      for (int i = 0; i < 120; i++) begin
         tick(0, 1, 0, 0, 0, "long");
         if (clr_plso) pulses++;
      end
      repeat (3) begin
         tick(0, 0, 0, 0, 0, "longr");
         if (clr_plso) pulses++;
      end
      check_val("long.pulses", 32'(pulses), 1);
      check_val("long.stm", 32'(stm), 0);

      // Short clr presses in RUN cycle the display mode.
      tick(1, 0, 0, 0, 0, "run2");
      repeat (2) tick(0, 0, 0, 0, 0, "run2r");
      repeat (3) begin
         repeat (5) tick(0, 1, 0, 0, 0, "short");
         repeat (2) tick(0, 0, 0, 0, 0, "shortr");
      end

      // Five laps into a four-deep FIFO, then drain.
      for (int i = 1; i <= 5; i++) begin
         tick(0, 0, 1, i * 10, 0, "lap");
         tick(0, 0, 0, i * 10, 0, "lapr");
      end
      check_val("lap.cnt4", 32'(lap_if.lap_cnt), 4);
      check_val("lap.ovf", 32'(lap_if.lap_ovf), 1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check_val("drain.data", 32'(lap_if.lap_data), 32'(i * 10));
         pop_between("drain");
      end
      @(negedge clk);
      check_val("drain.valid", 32'(lap_if.lap_valid), 0);

      // Simultaneous push and pop with two entries held.
      tick(0, 0, 1, 100, 0, "pp1");
      tick(0, 0, 0, 100, 0, "pp1r");
      tick(0, 0, 1, 200, 0, "pp2");
      tick(0, 0, 0, 200, 0, "pp2r");
      tick(0, 0, 1, 300, 0, "pp3");
      tick(0, 0, 0, 300, 1, "pp3r");
      check_val("pp.cnt", 32'(lap_if.lap_cnt), 2);
      check_val("pp.head", 32'(lap_if.lap_data), 200);

      // Random button traffic.
      st = 0; cl = 0; lp = 0;
      for (int i = 0; i < 350; i++) begin
         if ($urandom_range(0, 3) == 0) st = ~st;
         if ($urandom_range(0, 2) == 0) cl = ~cl;
         if ($urandom_range(0, 1) == 0) lp = ~lp;
         tick(st, cl, lp, int'($urandom_range(0, 65535)), $urandom_range(0, 5) == 0, "rnd");
         if ($urandom_range(0, 3) == 0) pop_between("rndpop");
      end

      // Async reset while running with three laps stored.
      do_reset();
      tick(1, 0, 0, 0, 0, "rr");
      tick(0, 0, 0, 0, 0, "rr");
      for (int i = 1; i <= 3; i++) begin
         tick(0, 0, 1, i, 0, "rrlap");
         tick(0, 0, 0, i, 0, "rrlapr");
      end
      check_val("rr.pre_cnt", 32'(lap_if.lap_cnt), 3);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check_val("arst.stm", 32'(stm), 0);
      check_val("arst.cnt_en", 32'(cnt_en), 0);
      check_val("arst.lap_cnt", 32'(lap_if.lap_cnt), 0);
      check_val("arst.ld0", 32'(ld0_rgb), 32'h2);
      check_val("arst.ld1", 32'(ld1_rgb), 32'h2);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (2) tick(0, 0, 0, 0, 0, "post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stop_watch_ctrl_mlap.md
Name: stop_watch_ctrl_mlap

Overview:
- Parametrised next-generation stopwatch control FSM.
- Generalises the tick-sampled IDLE/RUN/PAUSE controller with a configurable long-press threshold and N display modes.
- Adds a lap-capture FIFO that snapshots the external time counter on a lap button.
- Sits between the debounced board buttons and the stopwatch counter/display blocks; drives counter enable/clear, display-mode select and RGB status LEDs.

Parameters:
- TIME_W, 24, width of time_in / lap_data (counter value in ticks).
- LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2).
- DISP_MODES, 2, number of display modes (2..4).
- LONG_TICKS, 100, clr hold length in ticks that counts as a long press (>=2).

Ports:
- clk  in  1  system clock, 125 MHz.
- rst  in  1  asynchronous active-low reset.
- pls_tick  in  1  slow tick level (100 Hz square/pulse), clk-asynchronous-free.
- start_stop_btn  in  1  high-active start/stop.
- clr_btn  in  1  high-active clear/mode.
- lap_btn  in  1  high-active lap capture.
- time_in  in  TIME_W  current stopwatch count.
- lap_rd  in  1  pop request for lap FIFO.
- cnt_en  out  1  counter enable.
- clr_plso  out  1  counter clear.
- disp_mode  out  2  display mode, 0..DISP_MODES-1.
- stm  out  2  state: 0 IDLE, 1 RUN, 2 PAUSE.
- lap_valid  out  1  FIFO not empty.
- lap_data  out  TIME_W  FIFO head.
- lap_cnt  out  $clog2(LAP_DEPTH)+1  entries held.
- lap_ovf  out  1  sticky: lap dropped on full.
- ld0_rgb  out  3  state LED {r,g,b}.
- ld1_rgb  out  3  mode LED {r,g,b}.

Behaviour:
- Reset (rst=0, async): stm=0, disp_mode=0, cnt_en=0, clr_plso=0, FIFO empty, lap_ovf=0, lap_data=0, ld0_rgb=010, ld1_rgb=010, all sample regs and hold counter 0.
- Tick edges: pls_tick is 2-flop registered (p0, p1).
  - tick_r = p0 & ~p1.
  - tick_f = ~p0 & p1.
  - Each is a single-clk pulse.
- Buttons: sampled only on tick_r into s0/s1 pairs.
  - rise = s0 & ~s1.
  - fall = ~s0 & s1.
  - All FSM and button decisions below occur on tick_r cycles only.
- FSM on start rise:
  - IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - Start rise takes priority over long-clear in PAUSE.
- Hold counter:
  - Cleared on clr rise.
  - Otherwise increments while s0(clr)=1.
  - Saturates at LONG_TICKS.
- Long press:
  - Condition: hold counter == LONG_TICKS-1 and stm==PAUSE.
  - Effect: clr_pls=1 for one tick, stm->IDLE, FIFO flushed, lap_ovf cleared.
  - Fires once per press; a press started in RUN does not clear.
- Short press:
  - Condition: clr fall with hold counter < LONG_TICKS-1 and stm != IDLE.
  - Effect: disp_mode <= (disp_mode+1) mod DISP_MODES.
- disp_mode is forced to 0 whenever stm==IDLE.
- Lap capture:
  - Lap rise in RUN pushes time_in (as sampled that clk) into FIFO.
  - Lap rise in IDLE/PAUSE is ignored.
  - Push when full: entry dropped, lap_ovf<=1.
  - Flush has priority over push.
- Lap read: clk-domain handshake, independent of tick.
  - lap_rd & lap_valid pops at that clk edge.
  - lap_rd while empty is ignored.
  - Push and pop in the same clk: both occur, lap_cnt unchanged.
  - lap_data shows the head combinationally from FIFO storage.
- Outputs cnt_en, clr_plso, ld0_rgb, ld1_rgb are registered on tick_f, i.e. half a tick after the state change.
  - cnt_en = (stm==RUN).
  - clr_plso = clr_pls, high for one tick period.
- ld0_rgb: IDLE 010, RUN 001, PAUSE 111, 3 -> 000.
- ld1_rgb: mode0 010, mode1 001, mode2 100, mode3 110.
- stm==3 is unreachable; if entered, it holds.
- Reset mid-operation returns everything to reset values on the async assert.

Test Plan:
- Reset, then start press (held 3 ticks) -> stm=1 after the next tick_r; cnt_en=1 and ld0_rgb=001 at the following tick_f; a second press gives stm=2, cnt_en=0, ld0_rgb=111.
- In PAUSE, hold clr 120 ticks (LONG_TICKS=100) -> exactly one clr_plso pulse, one tick wide; stm=0; lap_cnt=0; disp_mode=0; no mode toggle on release.
- In RUN, clr pressed 5 ticks then released, repeated 3 times (DISP_MODES=3) -> disp_mode goes 1, 2, 0; ld1_rgb goes 001, 100, 010; stm stays 1.
- In RUN, 5 lap presses with time_in = 10, 20, 30, 40, 50 (LAP_DEPTH=4) -> lap_cnt=4, lap_ovf=1; pops return 10, 20, 30, 40; lap_valid drops after the 4th pop.
- FIFO holds 2 entries; lap push and lap_rd in the same clk -> lap_cnt stays 2, the old head is popped and the new value is appended at the tail.
- rst asserted while in RUN with 3 laps stored -> stm=0, cnt_en=0, lap_cnt=0, LEDs 010/010 immediately, without waiting for clk.
